led_scan_controller: RTL and testbench
======================================

LED_SCAN_CONTROLLER -- requirements
Module: LedScanController

Interface
REQ-001 Parameter DISPLAY_ROWS_LINES, default 4, SHALL set the scan-row address width (2^N scan rows; each scan row drives one line in the upper half and one in the lower half).
REQ-002 Parameter DISPLAY_COLS_LINES, default 6, SHALL set the column address width (2^N columns per line).
REQ-003 Parameter COLOR_BITS, default 8, SHALL set the number of bitplanes per colour.
REQ-004 Parameter BASE_DISPLAY, default 4, SHALL set the display time in clocks of bitplane 0.
REQ-005 clock_clk  in  1  SHALL be the single system clock; every register samples on its rising edge.
REQ-006 reset_rst  in  1  SHALL be the reset, asynchronous and active-low.
REQ-007 enable  in  1  SHALL be the scan enable: 1 = run frames, 0 = stop at the next frame boundary.
REQ-008 col  out  DISPLAY_COLS_LINES  SHALL be the pixel query column to the animation/pixel source.
REQ-009 row  out  DISPLAY_ROWS_LINES  SHALL be the pixel query scan row.
REQ-010 bitplane  out  4  SHALL be the pixel query bitplane index.
REQ-011 red1, green1, blue1, red2, green2, blue2  in  1 each  SHALL be the combinational pixel bits (upper/lower half) for the current col/row/bitplane.
REQ-012 r1_o, g1_o, b1_o, r2_o, g2_o, b2_o  out  1 each  SHALL be the registered HUB75 data lines.
REQ-013 panel_clk  out  1  SHALL be the HUB75 shift clock.
REQ-014 lat  out  1  SHALL be the HUB75 latch strobe, active-high.
REQ-015 oe_n  out  1  SHALL be the HUB75 output enable, active-low.
REQ-016 addr  out  DISPLAY_ROWS_LINES  SHALL be the HUB75 row select.
REQ-017 v_sync  out  1  SHALL be the one-cycle end-of-frame pulse to the animation block.

Function
REQ-018 The block SHALL implement FSM states IDLE, SHIFT, LATCH, DISPLAY.
REQ-019 IDLE: oe_n=1, panel_clk=0, lat=0; if enable=1, next cycle SHIFT with col=0, row=0, bitplane=0.
REQ-020 SHIFT: each column SHALL take 2 clocks -- phase 0: panel_clk=0, col=k held, data outputs register the six pixel inputs at end of phase; phase 1: panel_clk=1, data stable; then col increments.
REQ-021 After phase 1 of col=2^COLS-1, col SHALL wrap to 0 and the FSM SHALL enter LATCH; SHIFT length = 2*2^DISPLAY_COLS_LINES clocks.
REQ-022 LATCH: exactly 1 clock with lat=1, oe_n=1, panel_clk=0, and addr loaded from row in that cycle.
REQ-023 DISPLAY: oe_n=0 for exactly BASE_DISPLAY << bitplane clocks (binary-coded modulation), lat=0, panel_clk=0.
REQ-024 oe_n SHALL be 1 in every state other than DISPLAY; addr SHALL change only in LATCH.
REQ-025 End of DISPLAY: if bitplane < COLOR_BITS-1, bitplane+1 and SHIFT; else bitplane=0 and, if row < 2^ROWS-1, row+1 and SHIFT; else frame end.
REQ-026 Frame end: row=0, v_sync=1 for exactly the next clock; then SHIFT if enable=1, else IDLE.
REQ-027 enable deasserted mid-frame SHALL NOT abort the frame; it is sampled only at frame end and in IDLE.
REQ-028 Display counter SHALL be wide enough for BASE_DISPLAY << (COLOR_BITS-1) without overflow.
REQ-029 Per-frame clock count SHALL equal 2^ROWS * sum over b of (2*2^COLS + 1 + (BASE_DISPLAY<<b)), plus the 1 frame-end clock.

Reset
REQ-030 On reset_rst=0: state=IDLE, col=0, row=0, bitplane=0, all six data outputs=0, panel_clk=0, lat=0, oe_n=1, addr=0, v_sync=0, display counter=0.
REQ-031 Reset asserted mid-operation SHALL force these values immediately (asynchronously), regardless of state.
REQ-032 After reset release the block SHALL stay in IDLE until enable=1 is sampled.

Verification (COLS_LINES=2, ROWS_LINES=1, COLOR_BITS=2, BASE_DISPLAY=1)
REQ-033 Reset, enable=0 for 20 clocks -> oe_n=1, lat=0, panel_clk=0, v_sync never pulses.
REQ-034 enable=1, pixel source returning red1=col[0] -> r1_o sequence 0,1,0,1 on the 4 panel_clk rising edges; 4 panel_clk pulses per SHIFT.
REQ-035 enable=1 continuously -> oe_n low for 1 clock (plane 0) then 2 clocks (plane 1) per row; lat pulses 4 times per frame; v_sync period 43 clocks.
REQ-036 Check addr: 0 for rows latched with row=0, 1 after latch of row=1; never changes while oe_n=0.
REQ-037 Drop enable during row 0 plane 1 -> frame completes, v_sync pulses once, FSM enters IDLE, oe_n stays 1.
REQ-038 Assert reset_rst=0 during DISPLAY -> oe_n=1 and all outputs at reset values in the same cycle, before the next clock edge.

Source files
------------

// File: rtl/led_scan_controller.sv
// HUB75 LED matrix scan controller: shifts one line pair per bitplane, latches it,
// then lights it for a binary-weighted time (BCM), walking all rows each frame.
module led_scan_controller #(
    parameter int DISPLAY_ROWS_LINES = 4,
    parameter int DISPLAY_COLS_LINES = 6,
    parameter int COLOR_BITS         = 8,
    parameter int BASE_DISPLAY       = 4
) (
    input  logic                          clock_clk,
    input  logic                          reset_rst,
    input  logic                          enable,
    output logic [DISPLAY_COLS_LINES-1:0] col,
    output logic [DISPLAY_ROWS_LINES-1:0] row,
    output logic [3:0]                    bitplane,
    input  logic                          red1,
    input  logic                          green1,
    input  logic                          blue1,
    input  logic                          red2,
    input  logic                          green2,
    input  logic                          blue2,
    output logic                          r1_o,
    output logic                          g1_o,
    output logic                          b1_o,
    output logic                          r2_o,
    output logic                          g2_o,
    output logic                          b2_o,
    output logic                          panel_clk,
    output logic                          lat,
    output logic                          oe_n,
    output logic [DISPLAY_ROWS_LINES-1:0] addr,
    output logic                          v_sync
);

    localparam int MAX_DISP = BASE_DISPLAY << (COLOR_BITS - 1);
    localparam int CNT_W    = (MAX_DISP > 1) ? $clog2(MAX_DISP + 1) : 1;

    localparam logic [DISPLAY_COLS_LINES-1:0] COL_LAST   = '1;
    localparam logic [DISPLAY_ROWS_LINES-1:0] ROW_LAST   = '1;
    localparam logic [3:0]                    LAST_PLANE = 4'(COLOR_BITS - 1);
    localparam logic [CNT_W-1:0]              BASE_C     = CNT_W'(BASE_DISPLAY);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        LATCH   = 2'd2,
        DISPLAY = 2'd3
    } state_t;

    state_t                          state_q;
    logic                            phase_q;
    logic [CNT_W-1:0]                disp_cnt_q;
    logic [DISPLAY_COLS_LINES-1:0]   col_q;
    logic [DISPLAY_ROWS_LINES-1:0]   row_q;
    logic [3:0]                      bitplane_q;
    logic [DISPLAY_ROWS_LINES-1:0]   addr_q;
    logic [5:0]                      data_q;
    logic                            panel_clk_q;
    logic                            lat_q;
    logic                            oe_n_q;
    logic                            v_sync_q;

    // Counter preload is one less than the plane's on-time so the DISPLAY
    // state lasts exactly BASE_DISPLAY << plane clocks.
    function automatic logic [CNT_W-1:0] plane_time(input logic [3:0] plane);
        return (BASE_C << plane) - CNT_W'(1);
    endfunction

    always_ff @(posedge clock_clk or negedge reset_rst) begin
        if (!reset_rst) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            disp_cnt_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            bitplane_q  <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            panel_clk_q <= 1'b0;
            lat_q       <= 1'b0;
            oe_n_q      <= 1'b1;
            v_sync_q    <= 1'b0;
        end else begin
            v_sync_q <= 1'b0;
            case (state_q)
                // Also serves as the single frame-end clock (v_sync high).
                IDLE: begin
                    oe_n_q      <= 1'b1;
                    panel_clk_q <= 1'b0;
                    lat_q       <= 1'b0;
                    if (enable) begin
                        state_q    <= SHIFT;
                        phase_q    <= 1'b0;
                        col_q      <= '0;
                        row_q      <= '0;
                        bitplane_q <= '0;
                    end
                end
                SHIFT: begin
                    if (!phase_q) begin
                        phase_q     <= 1'b1;
                        panel_clk_q <= 1'b1;
                        data_q      <= {red1, green1, blue1, red2, green2, blue2};
                    end else begin
                        phase_q     <= 1'b0;
                        panel_clk_q <= 1'b0;
                        if (col_q == COL_LAST) begin
                            col_q   <= '0;
                            state_q <= LATCH;
                            lat_q   <= 1'b1;
                            addr_q  <= row_q;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    lat_q      <= 1'b0;
                    oe_n_q     <= 1'b0;
                    disp_cnt_q <= plane_time(bitplane_q);
                    state_q    <= DISPLAY;
                end
                DISPLAY: begin
                    if (disp_cnt_q == '0) begin
                        oe_n_q  <= 1'b1;
                        state_q <= SHIFT;
                        phase_q <= 1'b0;
                        if (bitplane_q < LAST_PLANE) begin
                            bitplane_q <= bitplane_q + 1'b1;
                        end else begin
                            bitplane_q <= '0;
                            if (row_q != ROW_LAST) begin
                                row_q <= row_q + 1'b1;
                            end else begin
                                row_q    <= '0;
                                state_q  <= IDLE;
                                v_sync_q <= 1'b1;
                            end
                        end
                    end else begin
                        disp_cnt_q <= disp_cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign col       = col_q;
    assign row       = row_q;
    assign bitplane  = bitplane_q;
    assign {r1_o, g1_o, b1_o, r2_o, g2_o, b2_o} = data_q;
    assign panel_clk = panel_clk_q;
    assign lat       = lat_q;
    assign oe_n      = oe_n_q;
    assign addr      = addr_q;
    assign v_sync    = v_sync_q;

endmodule

// File: tb/tb_led_scan_controller.sv
// Directed bench for led_scan_controller on a 4-column, 2-row, 2-plane panel.
module tb_led_scan_controller;

    localparam int RL = 1;
    localparam int CL = 2;
    localparam int CB = 2;
    localparam int BD = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [CL-1:0] col;
    logic [RL-1:0] row;
    logic [3:0]    bitplane;
    logic          red1, green1, blue1, red2, green2, blue2;
    logic          r1_o, g1_o, b1_o, r2_o, g2_o, b2_o;
    logic          panel_clk, lat, oe_n, v_sync;
    logic [RL-1:0] addr;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Pixel source: each data line carries a distinct function of the query.
    assign red1   = col[0];
    assign green1 = col[1];
    assign blue1  = bitplane[0];
    assign red2   = row[0];
    assign green2 = ~col[0];
    assign blue2  = col[0] ^ col[1];

    led_scan_controller #(
        .DISPLAY_ROWS_LINES(RL),
        .DISPLAY_COLS_LINES(CL),
        .COLOR_BITS(CB),
        .BASE_DISPLAY(BD)
    ) dut (
        .clock_clk(clk), .reset_rst(rst_n), .enable(enable),
        .col(col), .row(row), .bitplane(bitplane),
        .red1(red1), .green1(green1), .blue1(blue1),
        .red2(red2), .green2(green2), .blue2(blue2),
        .r1_o(r1_o), .g1_o(g1_o), .b1_o(b1_o),
        .r2_o(r2_o), .g2_o(g2_o), .b2_o(b2_o),
        .panel_clk(panel_clk), .lat(lat), .oe_n(oe_n),
        .addr(addr), .v_sync(v_sync)
    );

    task automatic test_reset();
        int bad = 0;
        int vs = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({oe_n, lat, panel_clk, v_sync} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 1000", {oe_n, lat, panel_clk, v_sync});
        end
        tests_run++;
        if ({r1_o, g1_o, b1_o, r2_o, g2_o, b2_o} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_data: got %b want 000000", {r1_o, g1_o, b1_o, r2_o, g2_o, b2_o});
        end
        tests_run++;
        if ({col, row, bitplane, addr} !== 8'b0) begin
            tests_failed++;
            $display("FAIL reset_query: got %b want 0", {col, row, bitplane, addr});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (oe_n !== 1'b1 || lat !== 1'b0 || panel_clk !== 1'b0) bad++;
            if (v_sync !== 1'b0) vs++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL idle_ctrl: %0d bad cycles want 0", bad);
        end
        tests_run++;
        if (vs != 0) begin
            tests_failed++;
            $display("FAIL idle_vsync: %0d pulses want 0", vs);
        end
    endtask

    task automatic test_shift();
        int pulses = 0;
        bit found = 0;
        logic prev = 1'b0;
        logic [3:0] r1seq = '0;
        logic [3:0] g1seq = '0;
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lat === 1'b1) begin
                found = 1;
                break;
            end
            if (panel_clk === 1'b1 && prev === 1'b0) begin
                pulses++;
                r1seq = {r1seq[2:0], r1_o};
                g1seq = {g1seq[2:0], g1_o};
            end
            prev = panel_clk;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL shift_latch_seen: got 0 want 1");
        end
        tests_run++;
        if (pulses != 4) begin
            tests_failed++;
            $display("FAIL shift_pulses: got %0d want 4", pulses);
        end
        tests_run++;
        if (r1seq !== 4'b0101) begin
            tests_failed++;
            $display("FAIL shift_r1_seq: got %b want 0101", r1seq);
        end
        tests_run++;
        if (g1seq !== 4'b0011) begin
            tests_failed++;
            $display("FAIL shift_g1_seq: got %b want 0011", g1seq);
        end
        tests_run++;
        if ({oe_n, panel_clk, addr, col} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL latch_state: got %b want 10000", {oe_n, panel_clk, addr, col});
        end
        @(negedge clk);
        tests_run++;
        if ({oe_n, lat} !== 2'b00) begin
            tests_failed++;
            $display("FAIL display_p0: got %b want 00", {oe_n, lat});
        end
        @(negedge clk);
        tests_run++;
        if ({oe_n, panel_clk, bitplane} !== 6'b10_0001) begin
            tests_failed++;
            $display("FAIL after_p0: got %b want 100001", {oe_n, panel_clk, bitplane});
        end
    endtask

    task automatic test_frame();
        bit found = 0;
        int n = 0, lats = 0, pulses = 0, r2ones = 0, b1ones = 0, addr_chg = 0, run = 0;
        int runs[$];
        int exp_runs[4] = '{1, 2, 1, 2};
        logic [3:0] lat_addrs = '0;
        logic prev_oe = 1'b1;
        logic prev_pclk = 1'b0;
        logic [RL-1:0] prev_addr;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (v_sync === 1'b1) begin
                found = 1;
                break;
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL frame1_vsync: got 0 want 1");
        end
        found = 0;
        prev_addr = addr;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (lat === 1'b1) begin
                lats++;
                lat_addrs = {lat_addrs[2:0], addr[0]};
            end
            if (oe_n === 1'b0) begin
                run++;
                if (addr !== prev_addr) addr_chg++;
            end else if (prev_oe === 1'b0) begin
                runs.push_back(run);
                run = 0;
            end
            if (panel_clk === 1'b1 && prev_pclk === 1'b0) begin
                pulses++;
                if (r2_o === 1'b1) r2ones++;
                if (b1_o === 1'b1) b1ones++;
            end
            prev_oe   = oe_n;
            prev_pclk = panel_clk;
            prev_addr = addr;
            if (v_sync === 1'b1) begin
                found = 1;
                break;
            end
        end
        tests_run++;
        if (!found || n != 43) begin
            tests_failed++;
            $display("FAIL vsync_period: got %0d (found %0d) want 43", n, found);
        end
        tests_run++;
        if (lats != 4) begin
            tests_failed++;
            $display("FAIL lat_count: got %0d want 4", lats);
        end
        tests_run++;
        if (lat_addrs !== 4'b0011) begin
            tests_failed++;
            $display("FAIL lat_addr_seq: got %b want 0011", lat_addrs);
        end
        tests_run++;
        if (runs.size() != 4) begin
            tests_failed++;
            $display("FAIL oe_run_count: got %0d want 4", runs.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (runs[k] != exp_runs[k]) begin
                    tests_failed++;
                    $display("FAIL oe_run_len[%0d]: got %0d want %0d", k, runs[k], exp_runs[k]);
                end
            end
        end
        tests_run++;
        if (pulses != 16) begin
            tests_failed++;
            $display("FAIL frame_pclk: got %0d want 16", pulses);
        end
        tests_run++;
        if (r2ones != 8 || b1ones != 8) begin
            tests_failed++;
            $display("FAIL frame_data: r2 %0d b1 %0d want 8 8", r2ones, b1ones);
        end
        tests_run++;
        if (addr_chg != 0) begin
            tests_failed++;
            $display("FAIL addr_during_oe: got %0d changes want 0", addr_chg);
        end
    endtask

    task automatic test_enable_drop();
        bit found = 0;
        int n = 0, bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bitplane === 4'd1 && row === 1'b0) begin
                found = 1;
                break;
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL drop_reach_plane1: got 0 want 1");
        end
        enable = 1'b0;
        found  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (v_sync === 1'b1) begin
                found = 1;
                break;
            end
        end
        tests_run++;
        if (!found || n != 32) begin
            tests_failed++;
            $display("FAIL drop_frame_end: got %0d (found %0d) want 32", n, found);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (oe_n !== 1'b1 || v_sync !== 1'b0 || panel_clk !== 1'b0 || lat !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL drop_idle: %0d bad cycles want 0", bad);
        end
        tests_run++;
        if ({col, row, bitplane} !== 7'b0) begin
            tests_failed++;
            $display("FAIL drop_query: got %b want 0", {col, row, bitplane});
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int bad = 0;
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (oe_n === 1'b0 && addr === 1'b1 && bitplane === 4'd1) begin
                found = 1;
                break;
            end
        end
        tests_run++;
        if (!found || r1_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_precond: found %0d r1 %b want 1 1", found, r1_o);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({oe_n, lat, panel_clk, v_sync} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL mid_reset_ctrl: got %b want 1000", {oe_n, lat, panel_clk, v_sync});
        end
        tests_run++;
        if ({r1_o, g1_o, b1_o, r2_o, g2_o, b2_o} !== 6'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_data: got %b want 000000", {r1_o, g1_o, b1_o, r2_o, g2_o, b2_o});
        end
        tests_run++;
        if ({col, row, bitplane, addr} !== 8'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_query: got %b want 0", {col, row, bitplane, addr});
        end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (oe_n !== 1'b1 || panel_clk !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: %0d bad cycles want 0", bad);
        end
        enable = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({panel_clk, r1_o, g2_o} !== 3'b101) begin
            tests_failed++;
            $display("FAIL restart_col0: got %b want 101", {panel_clk, r1_o, g2_o});
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_frame();
        test_enable_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
